pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage RV32 pipeline (optional counters: PIPE_PERF_CNT_EN)
module pipe_hazard_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       rs1_dec,
    input  logic [4:0]       rs2_dec,
    input  logic             use_rs1_dec,
    input  logic             use_rs2_dec,
    input  logic             ex_mem_r,
    input  logic [4:0]       ex_wb_addr,
    input  logic             pc_change_EX,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_flush,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int              BOOT_W      = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;
    localparam logic [BOOT_W-1:0] BOOT_INIT = BOOT_W'(BOOT_CYCLES);
    localparam logic [15:0]     TIMEOUT_VAL = 16'(MEM_TIMEOUT);
    localparam bit              TIMEOUT_EN  = (MEM_TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_BOOT     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BOOT_W-1:0] r_boot_cnt;
    logic [BOOT_W-1:0] w_boot_nxt;
    logic [15:0]       r_wait_cnt;
    logic [15:0]       w_wait_nxt;
    logic              r_halted;

    logic              w_mem_stall;
    logic              w_hazard;
    logic              w_resolve;

    // Memory stall and load-use detection; register x0 never creates a dependency.
    assign w_mem_stall = dmem_req && !dmem_ready;
    assign w_hazard    = ex_mem_r && (ex_wb_addr != 5'd0) &&
                         ((use_rs1_dec && (rs1_dec == ex_wb_addr)) ||
                          (use_rs2_dec && (rs2_dec == ex_wb_addr)));

    // State register, boot hold counter, memory wait counter and sticky halt flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_BOOT;
            r_boot_cnt <= BOOT_INIT;
            r_wait_cnt <= 16'd0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_boot_cnt <= w_boot_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_halted   <= r_halted || (w_state_nxt == S_HALT);
        end
    end

    // Next-state and strobe generation; the ready cycle of a memory wait reuses the RUN redirect/hazard logic.
    always_comb begin
        w_state_nxt = r_state;
        w_boot_nxt  = r_boot_cnt;
        w_wait_nxt  = r_wait_cnt;
        w_resolve   = 1'b0;
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_we    = 1'b0;
        ex_mem_we   = 1'b0;
        mem_wb_we   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        case (r_state)
            S_BOOT: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (r_boot_cnt == '0) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_boot_nxt = r_boot_cnt - 1'b1;
                end
            end
            S_RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt = S_MEM_WAIT;
                    w_wait_nxt  = 16'd1;
                end else begin
                    w_resolve = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (!dmem_ready) begin
                    if (r_wait_cnt != 16'hFFFF) begin
                        w_wait_nxt = r_wait_cnt + 16'd1;
                    end
                    if (TIMEOUT_EN && (r_wait_cnt == TIMEOUT_VAL)) begin
                        w_state_nxt = S_HALT;
                    end
                end else begin
                    w_state_nxt = S_RUN;
                    w_resolve   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_HALT;
            end
        endcase

        if (w_resolve) begin
            if (pc_change_EX) begin
                pc_we       = 1'b1;
                if_id_we    = 1'b1;
                id_ex_we    = 1'b1;
                ex_mem_we   = 1'b1;
                mem_wb_we   = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (w_hazard) begin
                id_ex_we    = 1'b1;
                ex_mem_we   = 1'b1;
                mem_wb_we   = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                pc_we       = 1'b1;
                if_id_we    = 1'b1;
                id_ex_we    = 1'b1;
                ex_mem_we   = 1'b1;
                mem_wb_we   = 1'b1;
            end
        end
    end

    assign halted = r_halted;

`ifdef PIPE_PERF_CNT_EN
    logic             w_active;
    logic             w_stall_evt;
    logic             w_flush_evt;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    assign w_active    = (r_state == S_RUN) || (r_state == S_MEM_WAIT);
    assign w_stall_evt = ((r_state == S_RUN) && w_mem_stall) ||
                         ((r_state == S_MEM_WAIT) && !dmem_ready) ||
                         (w_resolve && !pc_change_EX && w_hazard);
    assign w_flush_evt = w_resolve && pc_change_EX;

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_active) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
            if (w_stall_evt) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_evt) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign cycle_cnt = '0;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  rs1_dec, rs2_dec, ex_wb_addr;
    logic        use_rs1_dec, use_rs2_dec, ex_mem_r, pc_change_EX, dmem_req, dmem_ready;
    logic        pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_we, halted;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    pipe_hazard_ctrl #(
        .BOOT_CYCLES(2),
        .MEM_TIMEOUT(4),
        .CNT_W(32)
    ) dut (
        .clk(clk), .rstn(rstn),
        .rs1_dec(rs1_dec), .rs2_dec(rs2_dec),
        .use_rs1_dec(use_rs1_dec), .use_rs2_dec(use_rs2_dec),
        .ex_mem_r(ex_mem_r), .ex_wb_addr(ex_wb_addr),
        .pc_change_EX(pc_change_EX), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush),
        .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we), .halted(halted),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        rs1_dec = 5'd0; rs2_dec = 5'd0; use_rs1_dec = 1'b0; use_rs2_dec = 1'b0;
        ex_mem_r = 1'b0; ex_wb_addr = 5'd0; pc_change_EX = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Advance to the next falling edge, then let combinational outputs settle.
    task automatic next_cyc();
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        rstn = 1'b0;
        next_cyc(); #1;
        chk("rst_we",     {27'd0, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}, 32'd0);
        chk("rst_flush",  {30'd0, if_id_flush, id_ex_flush}, 32'd3);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_cnt",    cycle_cnt | stall_cnt | flush_cnt, 32'd0);

        // Boot hold: three cycles of frozen PC with bubbles, then RUN.
        next_cyc(); rstn = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("boot_pc_we_%0d", i), {31'd0, pc_we}, 32'd0);
            chk($sformatf("boot_flush_%0d", i), {30'd0, if_id_flush, id_ex_flush}, 32'd3);
            next_cyc(); #1;
        end
        chk("run_pc_we",  {31'd0, pc_we}, 32'd1);
        chk("run_we_all", {27'd0, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}, 32'h1F);
        chk("run_flush0", {30'd0, if_id_flush, id_ex_flush}, 32'd0);
        chk("cycle_cnt0", cycle_cnt, 32'd0);
        next_cyc(); #1;
        chk("cycle_cnt1", cycle_cnt, PERF ? 32'd1 : 32'd0);

        // Load-use on rs2: one-cycle bubble.
        ex_mem_r = 1'b1; ex_wb_addr = 5'd5; rs2_dec = 5'd5; use_rs2_dec = 1'b1; #1;
        chk("lu2_we",    {28'd0, pc_we, if_id_we, ex_mem_we, mem_wb_we}, 32'h3);
        chk("lu2_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd1);
        next_cyc(); ex_mem_r = 1'b0; #1;
        chk("lu2_after", {27'd0, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}, 32'h1F);
        chk("lu2_after_fl", {30'd0, if_id_flush, id_ex_flush}, 32'd0);

        // Load-use on rs1.
        next_cyc(); idle_inputs();
        ex_mem_r = 1'b1; ex_wb_addr = 5'd7; rs1_dec = 5'd7; use_rs1_dec = 1'b1; #1;
        chk("lu1_we", {28'd0, pc_we, if_id_we, ex_mem_we, mem_wb_we}, 32'h3);
        // Matching field but not used: no stall.
        next_cyc(); use_rs1_dec = 1'b0; #1;
        chk("lu1_unused", {31'd0, pc_we}, 32'd1);

        // x0 destination never stalls.
        next_cyc(); idle_inputs();
        ex_mem_r = 1'b1; ex_wb_addr = 5'd0; use_rs1_dec = 1'b1; use_rs2_dec = 1'b1; #1;
        chk("x0_pc_we", {31'd0, pc_we}, 32'd1);
        chk("x0_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd0);
        chk("stall_cnt_lu", stall_cnt, PERF ? 32'd2 : 32'd0);

        // Redirect wins over a simultaneous hazard.
        next_cyc(); idle_inputs();
        ex_mem_r = 1'b1; ex_wb_addr = 5'd9; rs1_dec = 5'd9; use_rs1_dec = 1'b1; pc_change_EX = 1'b1; #1;
        chk("redir_we",    {27'd0, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}, 32'h1F);
        chk("redir_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd3);
        next_cyc(); idle_inputs(); #1;
        chk("flush_cnt1", flush_cnt, PERF ? 32'd1 : 32'd0);
        chk("stall_cnt_redir", stall_cnt, PERF ? 32'd2 : 32'd0);

        // Ready without request is ignored.
        dmem_ready = 1'b1; #1;
        chk("rdy_noreq", {31'd0, pc_we}, 32'd1);
        next_cyc(); idle_inputs(); #1;
        chk("rdy_noreq_next", {31'd0, pc_we}, 32'd1);

        // Three-cycle memory stall, released on ready.
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mem_we_%0d", i), {27'd0, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}, 32'd0);
            chk($sformatf("mem_fl_%0d", i), {30'd0, if_id_flush, id_ex_flush}, 32'd0);
            next_cyc();
        end
        dmem_ready = 1'b1; #1;
        chk("mem_ready_we", {27'd0, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}, 32'h1F);
        next_cyc(); idle_inputs(); #1;
        chk("mem_back_run", {31'd0, pc_we}, 32'd1);
        chk("stall_cnt_mem", stall_cnt, PERF ? 32'd5 : 32'd0);

        // Redirect pending during a wait is taken on the ready cycle.
        dmem_req = 1'b1; pc_change_EX = 1'b1; #1;
        chk("pend_run_fl", {30'd0, if_id_flush, id_ex_flush}, 32'd0);
        chk("pend_run_pc", {31'd0, pc_we}, 32'd0);
        next_cyc(); #1;
        chk("pend_wait_fl", {30'd0, if_id_flush, id_ex_flush}, 32'd0);
        next_cyc(); dmem_ready = 1'b1; #1;
        chk("pend_rdy_fl", {30'd0, if_id_flush, id_ex_flush}, 32'd3);
        chk("pend_rdy_pc", {31'd0, pc_we}, 32'd1);
        next_cyc(); idle_inputs(); #1;
        chk("flush_cnt2", flush_cnt, PERF ? 32'd2 : 32'd0);
        chk("stall_cnt_pend", stall_cnt, PERF ? 32'd7 : 32'd0);

        // Timeout: RUN stall cycle plus four MEM_WAIT cycles, then HALT.
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("to_pc_we_%0d", i), {31'd0, pc_we}, 32'd0);
            chk($sformatf("to_halted_%0d", i), {31'd0, halted}, 32'd0);
            next_cyc();
        end
        #1;
        chk("halt_set", {31'd0, halted}, 32'd1);
        chk("halt_we",  {27'd0, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}, 32'd0);
        chk("stall_cnt_to", stall_cnt, PERF ? 32'd12 : 32'd0);
        next_cyc(); dmem_ready = 1'b1; pc_change_EX = 1'b1; #1;
        chk("halt_hold", {31'd0, halted}, 32'd1);
        chk("halt_hold_we", {31'd0, pc_we}, 32'd0);
        chk("halt_hold_fl", {30'd0, if_id_flush, id_ex_flush}, 32'd0);
        next_cyc(); #1;
        chk("halt_sticky", {31'd0, halted}, 32'd1);

        // Asynchronous reset away from a clock edge.
        #2; rstn = 1'b0; #1;
        chk("arst_halted", {31'd0, halted}, 32'd0);
        chk("arst_flush",  {30'd0, if_id_flush, id_ex_flush}, 32'd3);
        chk("arst_we",     {27'd0, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}, 32'd0);
        chk("arst_cnt",    cycle_cnt | stall_cnt | flush_cnt, 32'd0);
        next_cyc(); idle_inputs(); rstn = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reboot_pc_we_%0d", i), {31'd0, pc_we}, 32'd0);
            next_cyc(); #1;
        end
        chk("reboot_run", {31'd0, pc_we}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
